// File: rtl/mux_2_to_1.sv
// MDR input selector: combinational bus/memory mux plus a load-enabled registered copy.
// Optional source tag output src_q is enabled by defining MUX_SRC_TAG_EN.
module mux_2_to_1 #(
  parameter int unsigned           WIDTH       = 32,
  parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] BusMuxOut,
  input  logic [WIDTH-1:0] Mdatain,
  input  logic             select,
  input  logic             load,
  output logic [WIDTH-1:0] mux_output,
  output logic [WIDTH-1:0] mux_q,
`ifdef MUX_SRC_TAG_EN
  output logic             src_q,
`endif
  output logic             q_valid
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;

  // Ternary keeps bits where both inputs agree when select is X.
  assign mux_output = select ? Mdatain : BusMuxOut;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (load) begin
      data_d  = mux_output;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      data_q  <= RESET_VALUE;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign mux_q   = data_q;
  assign q_valid = valid_q;

`ifdef MUX_SRC_TAG_EN
  logic tag_q, tag_d;

  always_comb begin
    tag_d = tag_q;
    if (load) begin
      tag_d = select;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      tag_q <= 1'b0;
    end else begin
      tag_q <= tag_d;
    end
  end

  assign src_q = tag_q;
`endif

endmodule

// File: tb/tb_mux_2_to_1.sv
// Directed bench for mux_2_to_1; define MUX_SRC_TAG_EN to also exercise src_q.
module tb_mux_2_to_1;
  localparam int WIDTH = 32;

  logic             clk;
  logic             clk_en;
  logic             clr;
  logic [WIDTH-1:0] BusMuxOut;
  logic [WIDTH-1:0] Mdatain;
  logic             select;
  logic             load;
  logic [WIDTH-1:0] mux_output;
  logic [WIDTH-1:0] mux_q;
  logic             q_valid;
`ifdef MUX_SRC_TAG_EN
  logic             src_q;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  mux_2_to_1 #(.WIDTH(WIDTH), .RESET_VALUE('0)) dut (
    .clk        (clk),
    .clr        (clr),
    .BusMuxOut  (BusMuxOut),
    .Mdatain    (Mdatain),
    .select     (select),
    .load       (load),
    .mux_output (mux_output),
    .mux_q      (mux_q),
`ifdef MUX_SRC_TAG_EN
    .src_q      (src_q),
`endif
    .q_valid    (q_valid)
  );

  // Gated clock so the combinational path can be checked with no edges at all.
  initial clk = 1'b0;
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clk_en    = 1'b0;
    clr       = 1'b0;
    BusMuxOut = '0;
    Mdatain   = '0;
    select    = 1'b0;
    load      = 1'b0;
    #3;
    check("reset_mux_q", mux_q, 32'h0);
    check("reset_q_valid", {31'b0, q_valid}, 32'h0);
`ifdef MUX_SRC_TAG_EN
    check("reset_src_q", {31'b0, src_q}, 32'h0);
`endif

    // Combinational path with clock stopped and clear asserted
    BusMuxOut = 32'd16;
    Mdatain   = 32'd32;
    select    = 1'b0;
    #1;
    check("comb_sel0", mux_output, 32'd16);
    select = 1'b1;
    #1;
    check("comb_sel1", mux_output, 32'd32);
    check("no_clk_mux_q", mux_q, 32'h0);

    // Edge while clr=0 must not capture
    clk_en = 1'b1;
    load   = 1'b1;
    tick();
    check("clr_low_edge_mux_q", mux_q, 32'h0);
    check("clr_low_edge_valid", {31'b0, q_valid}, 32'h0);

    // Load 0xDEADBEEF, then clear between edges
    clr     = 1'b1;
    Mdatain = 32'hDEADBEEF;
    select  = 1'b1;
    tick();
    check("cap_deadbeef", mux_q, 32'hDEADBEEF);
    check("cap_deadbeef_valid", {31'b0, q_valid}, 32'h1);
    #2;
    clr = 1'b0;
    #1;
    check("async_clr_mux_q", mux_q, 32'h0);
    check("async_clr_valid", {31'b0, q_valid}, 32'h0);
`ifdef MUX_SRC_TAG_EN
    check("async_clr_src_q", {31'b0, src_q}, 32'h0);
`endif
    tick();

    // Capture memory data
    clr     = 1'b1;
    select  = 1'b1;
    Mdatain = 32'h12345678;
    load    = 1'b1;
    tick();
    check("cap_mem", mux_q, 32'h12345678);
    check("cap_mem_valid", {31'b0, q_valid}, 32'h1);
`ifdef MUX_SRC_TAG_EN
    check("cap_mem_src_q", {31'b0, src_q}, 32'h1);
`endif

    // Hold with load=0 across three edges
    load      = 1'b0;
    select    = 1'b0;
    BusMuxOut = 32'hAAAA5555;
    tick();
    tick();
    tick();
    check("hold_mux_q", mux_q, 32'h12345678);
    check("hold_valid", {31'b0, q_valid}, 32'h1);
    check("hold_comb", mux_output, 32'hAAAA5555);
`ifdef MUX_SRC_TAG_EN
    check("hold_src_q", {31'b0, src_q}, 32'h1);
`endif

    // Clear pulse between edges, then capture bus data after release
    #2;
    clr = 1'b0;
    #1;
    check("pulse_clr_mux_q", mux_q, 32'h0);
    check("pulse_clr_valid", {31'b0, q_valid}, 32'h0);
    #1;
    clr  = 1'b1;
    load = 1'b1;
    tick();
    check("release_cap_bus", mux_q, 32'hAAAA5555);
    check("release_cap_valid", {31'b0, q_valid}, 32'h1);
`ifdef MUX_SRC_TAG_EN
    check("release_src_q", {31'b0, src_q}, 32'h0);
`endif

    // Mixed-bit pattern through select=1 then select=0 captures
    Mdatain   = 32'h0F0F_F0F0;
    BusMuxOut = 32'h3C3C_C3C3;
    select    = 1'b1;
    tick();
    check("cap_pattern_mem", mux_q, 32'h0F0F_F0F0);
    select = 1'b0;
    #1;
    check("comb_pattern_bus", mux_output, 32'h3C3C_C3C3);
    tick();
    check("cap_pattern_bus", mux_q, 32'h3C3C_C3C3);

    // Clear held low over several edges with load=1
    clr = 1'b0;
    tick();
    tick();
    check("clr_held_mux_q", mux_q, 32'h0);
    check("clr_held_valid", {31'b0, q_valid}, 32'h0);
    check("clr_held_comb", mux_output, 32'h3C3C_C3C3);

    clk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
